// File: rtl/hazard_if.sv
// ============================================================================
// hazard_if : pipeline <-> hazard controller signal bundle
// Rev 1.0   : initial release
// ============================================================================
`default_nettype none

interface hazard_if;
  logic [4:0] ID_rs1_addr;
  logic [4:0] ID_rs2_addr;
  logic       ID_use_rs1;
  logic       ID_use_rs2;
  logic [4:0] EX_rd_addr;
  logic       EX_MemRead;
  logic       EX_md_valid;
  logic       EX_branch_taken;
  logic       md_done;
  logic       im_wait;
  logic       dm_wait;

  logic       pc_we;
  logic       if_id_we;
  logic       id_ex_we;
  logic       ex_mem_we;
  logic       mem_wb_we;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       md_start;

  // Pipeline side: supplies hazard sources, consumes enables/flushes.
  modport master (
    output ID_rs1_addr, ID_rs2_addr, ID_use_rs1, ID_use_rs2, EX_rd_addr,
           EX_MemRead, EX_md_valid, EX_branch_taken, md_done, im_wait, dm_wait,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush, md_start
  );

  modport slave (
    input  ID_rs1_addr, ID_rs2_addr, ID_use_rs1, ID_use_rs2, EX_rd_addr,
           EX_MemRead, EX_md_valid, EX_branch_taken, md_done, im_wait, dm_wait,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, ex_mem_flush, md_start
  );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : 5-stage pipeline hazard controller (load-use, branch, mul/div,
//               memory wait). Optional perf counters: HAZARD_PERF_CNT_EN.
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  hazard_if.slave               hz,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic mw;
  logic lu;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, ex_mem_flush, md_start;

  assign mw = hz.im_wait | hz.dm_wait;
  assign lu = hz.EX_MemRead && (hz.EX_rd_addr != 5'd0) &&
              ((hz.ID_use_rs1 && (hz.ID_rs1_addr == hz.EX_rd_addr)) ||
               (hz.ID_use_rs2 && (hz.ID_rs2_addr == hz.EX_rd_addr)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    pc_we        = 1'b0;
    if_id_we     = 1'b0;
    id_ex_we     = 1'b0;
    ex_mem_we    = 1'b0;
    mem_wb_we    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    md_start     = 1'b0;

    if (!rst_n) begin
      state_d = RUN;
    end else if (mw) begin
      // Whole pipeline frozen; a deferred md_start re-fires once mw drops.
      state_d = state_q;
    end else if ((state_q == MD_WAIT) && !hz.md_done) begin
      ex_mem_we    = 1'b1;
      mem_wb_we    = 1'b1;
      ex_mem_flush = 1'b1;
    end else if ((state_q == RUN) && hz.EX_md_valid) begin
      ex_mem_we    = 1'b1;
      mem_wb_we    = 1'b1;
      ex_mem_flush = 1'b1;
      md_start     = 1'b1;
      state_d      = MD_WAIT;
    end else begin
      if (state_q == MD_WAIT) state_d = RUN;
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      mem_wb_we = 1'b1;
      if (hz.EX_branch_taken) begin
        // The ID instruction is squashed, so a pending load-use is moot.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign hz.pc_we        = pc_we;
  assign hz.if_id_we     = if_id_we;
  assign hz.id_ex_we     = id_ex_we;
  assign hz.ex_mem_we    = ex_mem_we;
  assign hz.mem_wb_we    = mem_wb_we;
  assign hz.if_id_flush  = if_id_flush;
  assign hz.id_ex_flush  = id_ex_flush;
  assign hz.ex_mem_flush = ex_mem_flush;
  assign hz.md_start     = md_start;

`ifdef HAZARD_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && (stall_q != '1))      stall_q <= stall_q + CNT_ONE;
      if (if_id_flush && (flush_q != '1)) flush_q <= flush_q + CNT_ONE;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// ============================================================================
// tb_hazard_ctrl : scoreboard bench for hazard_ctrl
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // {pc, if_id, id_ex, ex_mem, mem_wb, f_if_id, f_id_ex, f_ex_mem, md_start}
  localparam logic [8:0] E_OFF = 9'b00000_000_0;
  localparam logic [8:0] E_NRM = 9'b11111_000_0;
  localparam logic [8:0] E_LU  = 9'b00111_010_0;
  localparam logic [8:0] E_BR  = 9'b11111_110_0;
  localparam logic [8:0] E_MDW = 9'b00011_001_0;
  localparam logic [8:0] E_MDS = 9'b00011_001_1;

  typedef struct packed {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, mdv, br, mdd, imw, dmw;
  } stim_t;

  typedef struct {
    string      name;
    logic [8:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  stim_t cur;

  hazard_if ifa ();
  hazard_if ifb ();

  assign ifa.ID_rs1_addr = cur.rs1;     assign ifb.ID_rs1_addr = cur.rs1;
  assign ifa.ID_rs2_addr = cur.rs2;     assign ifb.ID_rs2_addr = cur.rs2;
  assign ifa.ID_use_rs1  = cur.u1;      assign ifb.ID_use_rs1  = cur.u1;
  assign ifa.ID_use_rs2  = cur.u2;      assign ifb.ID_use_rs2  = cur.u2;
  assign ifa.EX_rd_addr  = cur.rd;      assign ifb.EX_rd_addr  = cur.rd;
  assign ifa.EX_MemRead  = cur.mr;      assign ifb.EX_MemRead  = cur.mr;
  assign ifa.EX_md_valid = cur.mdv;     assign ifb.EX_md_valid = cur.mdv;
  assign ifa.EX_branch_taken = cur.br;  assign ifb.EX_branch_taken = cur.br;
  assign ifa.md_done     = cur.mdd;     assign ifb.md_done     = cur.mdd;
  assign ifa.im_wait     = cur.imw;     assign ifb.im_wait     = cur.imw;
  assign ifa.dm_wait     = cur.dmw;     assign ifb.dm_wait     = cur.dmw;

  logic [31:0] stall_a, flush_a;
  logic [3:0]  stall_b, flush_b;

  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .hz(ifa), .stall_cnt(stall_a), .flush_cnt(flush_a)
  );

  hazard_ctrl #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .hz(ifb), .stall_cnt(stall_b), .flush_cnt(flush_b)
  );

  wire [8:0] obs = {ifa.pc_we, ifa.if_id_we, ifa.id_ex_we, ifa.ex_mem_we,
                    ifa.mem_wb_we, ifa.if_id_flush, ifa.id_ex_flush,
                    ifa.ex_mem_flush, ifa.md_start};

  function automatic stim_t st(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic u1, input logic u2,
                               input logic mr, input logic mdv, input logic br,
                               input logic mdd, input logic imw, input logic dmw);
    stim_t s;
    s = {rs1, rs2, rd, u1, u2, mr, mdv, br, mdd, imw, dmw};
    return s;
  endfunction

  // Common stimulus: ID add x6,x5,x1 against EX lw x5
  localparam stim_t S_NOP = '0;
  stim_t s_lu, s_lu_rd0, s_lu_rs2, s_rs2_nouse, s_noload;

  // Apply stimulus just after the active edge and queue the expected outputs.
  task automatic drive(input stim_t s, input string name, input logic [8:0] e);
    @(posedge clk); #1;
    cur = s;
    sb.push_back('{name, e});
  endtask

  task automatic test_reset();
    exp_t e;
    cur = S_NOP;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== E_OFF) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, E_OFF);
    end
    checks++;
    if (stall_a !== 32'd0 || flush_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_a, flush_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(S_NOP, "after_reset_run", E_NRM);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
    end
  endtask

  task automatic run_seq(input stim_t s[], input string n[], input logic [8:0] x[]);
    exp_t e;
    foreach (s[i]) begin
      drive(s[i], n[i], x[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e.v) begin
        errors++;
        $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
      end
    end
  endtask

  task automatic test_load_use();
    run_seq('{s_lu, S_NOP, s_lu_rd0, s_lu_rs2, s_rs2_nouse, s_noload},
            '{"lu_stall", "lu_next_advance", "lu_rd0_nostall", "lu_rs2_stall",
              "lu_rs2_unused", "lu_not_load"},
            '{E_LU, E_NRM, E_NRM, E_LU, E_NRM, E_NRM});
  endtask

  task automatic test_branch();
    stim_t lb, b;
    lb = s_lu;  lb.br = 1'b1;
    b  = S_NOP; b.br  = 1'b1;
    run_seq('{lb, b, S_NOP},
            '{"branch_over_lu", "branch_plain", "branch_after"},
            '{E_BR, E_BR, E_NRM});
  endtask

  task automatic test_muldiv();
    stim_t m, md, d;
    m  = S_NOP; m.mdv = 1'b1;
    md = m;     md.mdd = 1'b1;
    d  = S_NOP; d.mdd = 1'b1;
    run_seq('{m, m, m, m, md, S_NOP, d, S_NOP},
            '{"md_start", "md_wait1", "md_wait2", "md_wait3", "md_done_adv",
              "md_back_run", "md_done_in_run", "md_idle"},
            '{E_MDS, E_MDW, E_MDW, E_MDW, E_NRM, E_NRM, E_NRM, E_NRM});
  endtask

  task automatic test_mem_wait();
    stim_t w, mb, md, iw, wd;
    w  = S_NOP; w.dmw = 1'b1; w.br = 1'b1; w.mdv = 1'b1;
    mb = S_NOP; mb.mdv = 1'b1; mb.br = 1'b1;
    md = S_NOP; md.mdv = 1'b1; md.mdd = 1'b1;
    iw = S_NOP; iw.imw = 1'b1; iw.br = 1'b1;
    wd = md;    wd.dmw = 1'b1;
    run_seq('{w, w, w, mb, md, S_NOP, iw,
              mb, wd, mb, md, S_NOP},
            '{"mw_hold1", "mw_hold2", "mw_hold3", "mw_deferred_start",
              "mw_md_done", "mw_after", "imw_hold",
              "mwd_start", "mwd_done_lost", "mwd_still_wait", "mwd_done", "mwd_after"},
            '{E_OFF, E_OFF, E_OFF, E_MDS, E_NRM, E_NRM, E_OFF,
              E_MDS, E_OFF, E_MDW, E_NRM, E_NRM});
  endtask

  task automatic test_reset_mid_md();
    stim_t m;
    exp_t  e;
    m = S_NOP; m.mdv = 1'b1;
    run_seq('{m, m}, '{"rmd_start", "rmd_wait1"}, '{E_MDS, E_MDW});
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== E_OFF) begin
      errors++;
      $display("FAIL reset_mid_md: got %b expected %b", obs, E_OFF);
    end
    @(posedge clk); #1;
    cur = S_NOP;
    rst_n = 1'b1;
    sb.push_back('{"reset_mid_md_release", E_NRM});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if (obs !== e.v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", e.name, obs, e.v);
    end
  endtask

  task automatic test_counters();
    stim_t b;
    int    exp_sa, exp_fa, exp_sb, exp_fb;
    b = S_NOP; b.br = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    cur = S_NOP;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; cur = s_lu;
      @(posedge clk); #1; cur = S_NOP;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; cur = b;
    end
    @(posedge clk); #1; cur = S_NOP;
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    exp_sa = 10; exp_fa = 3; exp_sb = 10; exp_fb = 3;
`else
    exp_sa = 0;  exp_fa = 0; exp_sb = 0;  exp_fb = 0;
`endif
    checks++;
    if (stall_a !== 32'(exp_sa)) begin
      errors++; $display("FAIL stall_cnt_10: got %0d expected %0d", stall_a, exp_sa);
    end
    checks++;
    if (flush_a !== 32'(exp_fa)) begin
      errors++; $display("FAIL flush_cnt_3: got %0d expected %0d", flush_a, exp_fa);
    end
    checks++;
    if (stall_b !== 4'(exp_sb) || flush_b !== 4'(exp_fb)) begin
      errors++;
      $display("FAIL w4_cnt_10_3: got %0d/%0d expected %0d/%0d",
               stall_b, flush_b, exp_sb, exp_fb);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1; cur = s_lu;
      @(posedge clk); #1; cur = S_NOP;
    end
    @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    exp_sa = 20; exp_sb = 15;
`endif
    checks++;
    if (stall_a !== 32'(exp_sa)) begin
      errors++; $display("FAIL stall_cnt_20: got %0d expected %0d", stall_a, exp_sa);
    end
    checks++;
    if (stall_b !== 4'(exp_sb)) begin
      errors++; $display("FAIL w4_stall_sat: got %0d expected %0d", stall_b, exp_sb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    s_lu        = st(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    s_lu_rd0    = st(5'd0, 5'd1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    s_lu_rs2    = st(5'd3, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    s_rs2_nouse = st(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    s_noload    = st(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cur = S_NOP;

    test_reset();
    test_load_use();
    test_branch();
    test_muldiv();
    test_mem_wait();
    test_reset_mid_md();
    test_counters();

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
